// File: rtl/rd_fault_isolator.sv
// rd_fault_isolator: read-channel isolation stage behind the read guard.
// Tracks outstanding read bursts and completes them with SLVERR on reset.
package rd_fault_isolator_pkg;
    typedef logic [3:0] axi_id_t;
    typedef struct packed {
        axi_id_t     id;
        logic [31:0] addr;
        logic [7:0]  len;
    } axi_ax_t;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } axi_w_t;
    typedef struct packed {
        axi_id_t    id;
        logic [1:0] resp;
    } axi_b_t;
    typedef struct packed {
        axi_id_t     id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;
    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axi_b_t  b;
        logic    b_valid;
        logic    ar_ready;
        axi_r_t  r;
        logic    r_valid;
    } axi_rsp_t;
endpackage

module rd_fault_isolator #(
    parameter int  MaxRdTxns   = 32,
    parameter int  ResetCycles = 16,
    parameter type req_t       = rd_fault_isolator_pkg::axi_req_t,
    parameter type rsp_t       = rd_fault_isolator_pkg::axi_rsp_t,
    parameter type id_t        = rd_fault_isolator_pkg::axi_id_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reset_req_i,
    output logic reset_clear_o,
    output logic slv_rst_o,
    input  req_t mst_req_i,
    output rsp_t mst_rsp_o,
    output req_t slv_req_o,
    input  rsp_t slv_rsp_i,
    output logic busy_o
);
    localparam int IdxW = (MaxRdTxns > 1) ? $clog2(MaxRdTxns) : 1;
    localparam int CntW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;

    localparam logic [1:0] ST_PASS    = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_SLV_RST = 2'd2;
    localparam logic [1:0] ST_CLEAR   = 2'd3;

    logic [1:0]           r_state;
    logic [CntW-1:0]      r_cnt;
    logic                 r_clr_done;
    logic [MaxRdTxns-1:0] r_vld;
    id_t                  r_id   [MaxRdTxns];
    logic [7:0]           r_len  [MaxRdTxns];
    logic [7:0]           r_beat [MaxRdTxns];
    logic [IdxW-1:0]      r_rank [MaxRdTxns];

    logic                 w_pass;
    logic                 w_flush;
    logic                 w_hit;
    logic [IdxW-1:0]      w_hit_idx;
    logic                 w_upd;
    logic                 w_last;
    logic                 w_free;
    logic [MaxRdTxns-1:0] w_vld_nxt;
    logic                 w_slot;
    logic [IdxW-1:0]      w_slot_idx;
    logic [IdxW-1:0]      w_same;
    logic                 w_full;
    logic                 w_ar_rdy;
    logic                 w_ar_hs;

    assign w_pass  = (r_state == ST_PASS);
    assign w_flush = (r_state == ST_FLUSH);

    // PASS: entry addressed by the slave beat; FLUSH: lowest rank-0 entry
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < MaxRdTxns; i++) begin
            if (!w_hit && r_vld[i] && (r_rank[i] == '0) &&
                (w_flush || (r_id[i] == slv_rsp_i.r.id))) begin
                w_hit     = 1'b1;
                w_hit_idx = IdxW'(i);
            end
        end
    end

    assign w_upd  = w_hit && mst_req_i.r_ready &&
                    (w_flush || (w_pass && slv_rsp_i.r_valid));
    assign w_last = w_pass ? slv_rsp_i.r.last
                           : (r_beat[w_hit_idx] == r_len[w_hit_idx]);
    assign w_free = w_upd && w_last;

    always_comb begin
        w_vld_nxt = r_vld;
        if (w_free) begin
            w_vld_nxt[w_hit_idx] = 1'b0;
        end
    end

    // Allocation sees the table with this cycle's free already applied
    always_comb begin
        w_slot     = 1'b0;
        w_slot_idx = '0;
        w_same     = '0;
        for (int i = 0; i < MaxRdTxns; i++) begin
            if (!w_slot && !w_vld_nxt[i]) begin
                w_slot     = 1'b1;
                w_slot_idx = IdxW'(i);
            end
            if (w_vld_nxt[i] && (r_id[i] == mst_req_i.ar.id)) begin
                w_same = w_same + 1'b1;
            end
        end
    end

    assign w_full   = !w_slot;
    assign w_ar_rdy = !w_full &&
                      ((w_pass && slv_rsp_i.ar_ready) || w_flush);
    assign w_ar_hs  = mst_req_i.ar_valid && w_ar_rdy;

    always_comb begin
        slv_req_o          = mst_req_i;
        mst_rsp_o          = slv_rsp_i;
        slv_req_o.ar_valid = 1'b0;
        slv_req_o.r_ready  = 1'b0;
        mst_rsp_o.ar_ready = w_ar_rdy;
        mst_rsp_o.r_valid  = 1'b0;
        case (r_state)
            ST_PASS: begin
                slv_req_o.ar_valid = mst_req_i.ar_valid && !w_full;
                slv_req_o.r_ready  = mst_req_i.r_ready;
                mst_rsp_o.r_valid  = slv_rsp_i.r_valid;
            end
            ST_FLUSH: begin
                mst_rsp_o.r_valid = w_hit;
                mst_rsp_o.r.id    = r_id[w_hit_idx];
                mst_rsp_o.r.data  = '0;
                mst_rsp_o.r.resp  = 2'b10;
                mst_rsp_o.r.last  = w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < MaxRdTxns; i++) begin
                if (w_free && (IdxW'(i) == w_hit_idx)) begin
                    r_vld[i] <= 1'b0;
                end else if (w_free && r_vld[i] &&
                             (r_id[i] == r_id[w_hit_idx])) begin
                    r_rank[i] <= r_rank[i] - 1'b1;
                end
            end
            if (w_upd) begin
                r_beat[w_hit_idx] <= r_beat[w_hit_idx] + 8'd1;
            end
            if (w_ar_hs) begin
                r_vld[w_slot_idx]  <= 1'b1;
                r_id[w_slot_idx]   <= mst_req_i.ar.id;
                r_len[w_slot_idx]  <= mst_req_i.ar.len;
                r_beat[w_slot_idx] <= 8'd0;
                r_rank[w_slot_idx] <= w_same;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_PASS;
            r_cnt      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (reset_req_i) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!(|r_vld) && !w_ar_hs) begin
                        r_state <= ST_SLV_RST;
                        r_cnt   <= '0;
                    end
                end
                ST_SLV_RST: begin
                    if (r_cnt == CntW'(ResetCycles - 1)) begin
                        r_state    <= ST_CLEAR;
                        r_clr_done <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_clr_done <= 1'b1;
                    if (!reset_req_i) begin
                        r_state <= ST_PASS;
                    end
                end
            endcase
        end
    end

    assign slv_rst_o     = (r_state == ST_SLV_RST);
    assign reset_clear_o = (r_state == ST_CLEAR) && !r_clr_done;
    assign busy_o        = !w_pass;

endmodule

// File: tb/tb_rd_fault_isolator.sv
// tb_rd_fault_isolator: randomized bench against a slot/queue model
// of the read isolator, plus directed flush and reset sequences.
module tb_rd_fault_isolator;
    import rd_fault_isolator_pkg::*;

    localparam int N  = 32;
    localparam int RC = 16;
    localparam int P_PASS  = 0;
    localparam int P_FLUSH = 1;
    localparam int P_RST   = 2;
    localparam int P_CLR   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst;
    logic     rreq;
    logic     clr;
    logic     srst;
    logic     busy;
    axi_req_t mreq;
    axi_req_t sreq;
    axi_rsp_t mrsp;
    axi_rsp_t srsp;

    rd_fault_isolator #(
        .MaxRdTxns  (N),
        .ResetCycles(RC),
        .req_t      (axi_req_t),
        .rsp_t      (axi_rsp_t),
        .id_t       (axi_id_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reset_req_i  (rreq),
        .reset_clear_o(clr),
        .slv_rst_o    (srst),
        .mst_req_i    (mreq),
        .mst_rsp_o    (mrsp),
        .slv_req_o    (sreq),
        .slv_rsp_i    (srsp),
        .busy_o       (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: slots allocated lowest-free, per-ID queues give AXI order
    int ph;
    int rcnt;
    bit clr_sent;
    bit mv    [N];
    int mid   [N];
    int mlen  [N];
    int mbeat [N];
    int q     [16][$];

    logic   o_arr, o_rv, o_sarv, o_rst, o_clr, o_busy;
    axi_r_t o_r;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        for (int k = 0; k < 16; k++) q[k].delete();
        ph = P_PASS;
        rcnt = 0;
        clr_sent = 1'b0;
    endtask

    task automatic step();
        int cnt, sel, fs, rid, s;
        bit fr, full, arhs, e_arr, e_sarv, e_srr, e_rv;
        axi_r_t er;
        cnt = 0; sel = -1; fs = -1; fr = 1'b0; s = -1;
        #1;
        for (int i = 0; i < N; i++) if (mv[i]) cnt++;
        rid = int'(srsp.r.id);
        if (ph == P_PASS) begin
            if (srsp.r_valid && mreq.r_ready && q[rid].size() > 0) begin
                fs = q[rid][0];
                fr = srsp.r.last;
            end
        end else if (ph == P_FLUSH) begin
            for (int i = 0; i < N; i++)
                if (sel < 0 && mv[i] && q[mid[i]][0] == i) sel = i;
            if (sel >= 0 && mreq.r_ready) begin
                fs = sel;
                fr = (mbeat[sel] == mlen[sel]);
            end
        end
        full   = (cnt - (fr ? 1 : 0)) == N;
        e_arr  = (ph == P_PASS) ? (srsp.ar_ready && !full)
               : (ph == P_FLUSH) ? !full : 1'b0;
        e_sarv = (ph == P_PASS) && mreq.ar_valid && !full;
        e_srr  = (ph == P_PASS) && mreq.r_ready;
        e_rv   = (ph == P_PASS) ? srsp.r_valid : (ph == P_FLUSH && sel >= 0);
        arhs   = mreq.ar_valid && e_arr;
        chk("ar_ready", 64'(mrsp.ar_ready), 64'(e_arr));
        chk("slv_ar_valid", 64'(sreq.ar_valid), 64'(e_sarv));
        chk("slv_r_ready", 64'(sreq.r_ready), 64'(e_srr));
        chk("r_valid", 64'(mrsp.r_valid), 64'(e_rv));
        if (e_rv && ph == P_PASS) chk("r_pass", 64'(mrsp.r), 64'(srsp.r));
        if (e_rv && ph == P_FLUSH) begin
            er.id   = axi_id_t'(mid[sel]);
            er.data = '0;
            er.resp = 2'b10;
            er.last = (mbeat[sel] == mlen[sel]);
            chk("r_err", 64'(mrsp.r), 64'(er));
        end
        chk("slv_rst", 64'(srst), 64'(ph == P_RST));
        chk("clear", 64'(clr), 64'(ph == P_CLR && !clr_sent));
        chk("busy", 64'(busy), 64'(ph != P_PASS));
        chk("aw_fwd", 64'({sreq.aw_valid, sreq.aw}),
            64'({mreq.aw_valid, mreq.aw}));
        chk("w_fwd", 64'({sreq.w_valid, sreq.w, sreq.b_ready}),
            64'({mreq.w_valid, mreq.w, mreq.b_ready}));
        chk("b_fwd", 64'({mrsp.aw_ready, mrsp.w_ready, mrsp.b_valid, mrsp.b}),
            64'({srsp.aw_ready, srsp.w_ready, srsp.b_valid, srsp.b}));
        chk("ar_fwd", 64'(sreq.ar), 64'(mreq.ar));
        o_arr = mrsp.ar_ready; o_rv = mrsp.r_valid; o_sarv = sreq.ar_valid;
        o_rst = srst; o_clr = clr; o_busy = busy; o_r = mrsp.r;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (fs >= 0) begin
                if (fr) begin
                    mv[fs] = 1'b0;
                    void'(q[mid[fs]].pop_front());
                end else begin
                    mbeat[fs]++;
                end
            end
            if (arhs) begin
                for (int i = 0; i < N; i++) if (s < 0 && !mv[i]) s = i;
                mv[s] = 1'b1;
                mid[s] = int'(mreq.ar.id);
                mlen[s] = int'(mreq.ar.len);
                mbeat[s] = 0;
                q[mid[s]].push_back(s);
            end
            case (ph)
                P_PASS:  if (rreq) ph = P_FLUSH;
                P_FLUSH: if (cnt == 0 && !arhs) begin ph = P_RST; rcnt = 0; end
                P_RST: begin
                    rcnt++;
                    if (rcnt == RC) begin ph = P_CLR; clr_sent = 1'b0; end
                end
                default: begin
                    clr_sent = 1'b1;
                    if (!rreq) ph = P_PASS;
                end
            endcase
        end
        #1;
    endtask

    task automatic drain(output int nb, output int pat, output int lid,
                         output int nrst, output int nclr, output int sav);
        nb = 0; pat = 0; lid = -1; nrst = 0; nclr = 0; sav = 0;
        for (int k = 0; k < 200 && nclr == 0; k++) begin
            step();
            if (o_rv && mreq.r_ready) begin
                nb++;
                pat = pat * 2 + int'(o_r.last);
                lid = int'(o_r.id);
            end
            nrst += int'(o_rst); nclr += int'(o_clr); sav += int'(o_sarv);
        end
        rreq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            nrst += int'(o_rst); nclr += int'(o_clr);
        end
    endtask

    task automatic rnd_inputs(input int rv_pct);
        logic [191:0] rb;
        int rid;
        rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mreq = rb[$bits(axi_req_t)-1:0];
        rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        srsp = rb[$bits(axi_rsp_t)-1:0];
        mreq.ar_valid = $urandom_range(1) == 1;
        mreq.ar.id    = 4'($urandom_range(3));
        mreq.ar.len   = 8'($urandom_range(3));
        mreq.r_ready  = $urandom_range(9) < 8;
        srsp.ar_ready = $urandom_range(9) < 7;
        srsp.r_valid  = $urandom_range(99) < rv_pct;
        rid = $urandom_range(4);
        srsp.r.id = 4'(rid);
        if (q[rid].size() > 0)
            srsp.r.last = (mbeat[q[rid][0]] == mlen[q[rid][0]]);
    endtask

    int nb, pat, lid, nrst, nclr, sav, acc;

    initial begin
        mreq = '0; srsp = '0; rreq = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;
        step();
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_slv_rst", 64'(o_rst), 64'd0);
        chk("rst_clear", 64'(o_clr), 64'd0);

        // Same-ID bursts, one beat delivered before the reset request
        srsp.ar_ready = 1'b1;
        mreq.ar_valid = 1'b1; mreq.ar.id = 4'd5; mreq.ar.len = 8'd1;
        step();
        mreq.ar.len = 8'd2;
        step();
        mreq.ar_valid = 1'b0;
        srsp.r_valid = 1'b1; srsp.r.id = 4'd5; srsp.r.last = 1'b0;
        mreq.r_ready = 1'b1;
        step();
        srsp.r_valid = 1'b0;
        rreq = 1'b1;
        drain(nb, pat, lid, nrst, nclr, sav);
        chk("same_id_beats", 64'(nb), 64'd4);
        chk("same_id_lasts", 64'(pat), 64'd9);
        chk("same_id_lid", 64'(lid), 64'd5);
        chk("seq_slv_rst_cycles", 64'(nrst), 64'd16);
        chk("seq_clear_pulses", 64'(nclr), 64'd1);
        chk("seq_back_to_pass", 64'(o_busy), 64'd0);

        // AR arriving during FLUSH is answered locally
        rreq = 1'b1; mreq.r_ready = 1'b0;
        step();
        mreq.ar_valid = 1'b1; mreq.ar.id = 4'd7; mreq.ar.len = 8'd0;
        step();
        acc = int'(o_sarv);
        mreq.ar_valid = 1'b0; mreq.r_ready = 1'b1;
        drain(nb, pat, lid, nrst, nclr, sav);
        chk("flush_ar_beats", 64'(nb), 64'd1);
        chk("flush_ar_last", 64'(pat), 64'd1);
        chk("flush_ar_id", 64'(lid), 64'd7);
        chk("flush_ar_slv_valid", 64'(sav + acc), 64'd0);
        chk("flush_ar_rst_cycles", 64'(nrst), 64'd16);

        // Fill the table, then free one entry with r.last
        mreq.r_ready = 1'b0; srsp.ar_ready = 1'b1; acc = 0;
        for (int k = 0; k < 40 && acc < N; k++) begin
            mreq.ar_valid = 1'b1; mreq.ar.id = 4'(k % 4); mreq.ar.len = 8'd0;
            step();
            acc += int'(o_arr);
        end
        chk("fill_count", 64'(acc), 64'(N));
        step();
        chk("full_ar_ready", 64'(o_arr), 64'd0);
        srsp.r_valid = 1'b1; srsp.r.id = 4'd0; srsp.r.last = 1'b1;
        mreq.r_ready = 1'b1;
        step();
        chk("free_ar_ready", 64'(o_arr), 64'd1);

        // Synchronous reset in the middle of a flush
        srsp.r_valid = 1'b0; mreq.ar_valid = 1'b0; mreq.r_ready = 1'b0;
        rreq = 1'b1;
        step();
        step();
        chk("flush_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; rreq = 1'b0; mreq.ar_valid = 1'b1;
        step();
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_slv_rst", 64'(o_rst), 64'd0);
        chk("midrst_ar_ready", 64'(o_arr), 64'd1);

        for (int c = 0; c < 5000; c++) begin
            rnd_inputs(((c / 500) % 2 == 1) ? 5 : 45);
            if (ph == P_PASS && !rreq && $urandom_range(99) < 2) rreq = 1'b1;
            else if (ph == P_CLR && $urandom_range(2) == 0) rreq = 1'b0;
            rst = ($urandom_range(999) == 0);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rd_fault_isolator.md
# rd_fault_isolator

Read-channel isolation stage placed directly downstream of the read guard, between the guarded master and the slave AR/R channels. In normal operation it forwards AR and R unchanged while tracking every outstanding read burst. When the guard raises its reset request, the block cuts the slave off and completes every tracked and newly arriving burst towards the master with SLVERR beats. It then pulses a reset to the slave and returns the clear handshake that releases the guard's reset request.

## Interface
- MaxRdTxns, 32: depth of the outstanding-burst table; the only capacity limit.
- ResetCycles, 16: cycles slv_rst_o is held high; ≥1.
- req_t, logic: AXI request struct; AR, R and W fields as in the guard.
- rsp_t, logic: AXI response struct.
- id_t, logic: AXI ID type.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high; all state returns to reset values on the next edge.
- reset_req_i  in  1  level reset request from the read guard.
- reset_clear_o  out  1  one-cycle clear pulse to the guard; reset value 0.
- slv_rst_o  out  1  slave reset, active-high; reset value 0.
- mst_req_i  in  req_t  master request.
- mst_rsp_o  out  rsp_t  response to the master.
- slv_req_o  out  req_t  request to the slave.
- slv_rsp_i  in  rsp_t  slave response.
- busy_o  out  1  high in any state other than PASS; reset value 0.

## Operation
- Write channels (AW, W, B) are forwarded combinationally in every state; they are not touched by this block.
- Table entry: valid, id, len (8 b), beat (8 b), rank (clog2(MaxRdTxns) b). Reset: all entries invalid.
- FSM states: PASS, FLUSH, SLV_RST, CLEAR. Reset state: PASS.
- PASS:
  - AR and R are forwarded combinationally.
  - When the table is full, master ar_ready and slave ar_valid are forced to 0.
  - An AR handshake allocates the lowest free entry: id, len, beat=0, rank = number of valid entries with the same id.
  - An R handshake targets the valid entry with matching id and rank 0, and increments its beat.
  - An r.last handshake frees that entry and decrements rank of every other valid entry with the same id.
  - An R beat with no matching entry is forwarded unchanged; the table is not modified.
  - reset_req_i=1 moves to FLUSH on the next edge. An AR or R handshake in that same cycle is still recorded.
- FLUSH:
  - Slave is isolated: slv ar_valid=0 and slv r_ready=0. Slave R content is ignored.
  - Master R is generated internally from the lowest-index valid entry with rank 0.
    - Generated beat fields: id=entry id, data=0, resp=2'b10, last=(beat==len).
  - Each master r_ready handshake increments beat. The last beat frees the entry and updates ranks as in PASS.
  - Master ARs are accepted while the table is not full and allocated as in PASS. They are never forwarded to the slave.
  - When the table is empty and no AR handshake occurs this cycle, move to SLV_RST.
- SLV_RST:
  - Master ar_ready=0, master r_valid=0, slv_rst_o=1.
  - A cycle counter runs from 0; after ResetCycles cycles, move to CLEAR.
- CLEAR:
  - reset_clear_o=1 for exactly one cycle, then wait in CLEAR with ar_ready=0 until reset_req_i=0, then go to PASS.
  - Master ARs remain blocked for this whole time.
- rst_i in any state: FSM to PASS, table cleared, slv_rst_o and reset_clear_o low next cycle. Master-visible bursts in flight are abandoned.

## Timing
- PASS adds zero cycles on AR and R; all valid/ready paths are combinational.
- Isolation takes effect in the cycle after reset_req_i is sampled high.
- In FLUSH, one error beat is issued per cycle while the master holds r_ready. A burst of len=L takes L+1 cycles. There are no bubbles between consecutive bursts.
- SLV_RST lasts exactly ResetCycles cycles. The reset_clear_o pulse occurs in the first CLEAR cycle.
- If reset_req_i is already low when CLEAR is entered, return to PASS after 1 cycle.
- Simultaneous AR allocation and last-beat free in one cycle: the free is applied first, so the freed slot is reusable in the same cycle only if it is the lowest free index. The rank is computed excluding the freed entry.

## Test plan
- Pass-through: 4 ARs (id 0..3, len 3), slave answers out of order → all beats reach the master unchanged; the table is empty after the last r.last; busy_o stays 0.
- Same-ID ordering: 2 ARs id=5 (len 1, len 2), reset_req after the first R beat → FLUSH emits 1 SLVERR beat (last=1) for the first burst, then 3 SLVERR beats for the second.
- New AR during FLUSH: AR id=7 len=0 arrives in FLUSH → 1 SLVERR beat with last=1; the slave never sees ar_valid.
- Reset sequence: empty table, reset_req pulse → slv_rst_o high for exactly ResetCycles=16 cycles, reset_clear_o high for 1 cycle, PASS once reset_req is low.
- Full table: MaxRdTxns ARs with no R → master ar_ready=0. One r.last frees an entry → ar_ready=1 the same cycle.
- rst_i asserted mid-FLUSH → next cycle: PASS, table empty, busy_o=0, slv_rst_o=0.
